alu_share_arbiter: RTL and testbench

- Shares one ALU and its ALU control decoder between two requesters: requester 0 is the main datapath execute stage, requester 1 is the branch/address unit.
- Arbitrates round-robin and registers the winning operation into a single issue stage. That stage drives ALUOp/Func to the ALU control decoder and the operands to the ALU.
- Captures the ALU result into a one-entry response buffer per requester.

---
 rtl/alu_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
//------------------------------------------------------------------------------
// alu_share_arbiter : round-robin sharing of one ALU between two requesters,
//                     with a single issue stage and a one-entry response buffer
//                     per requester.
// Option macro      : ALU_ARB_FIXED_PRIO_EN (requester 0 always wins ties)
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_ALUOp,
  input  logic [5:0]       req0_Func,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_ALUOp,
  input  logic [5:0]       req1_Func,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_valid,
  output logic [1:0]       alu_ALUOp,
  output logic [5:0]       alu_Func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero
);

  logic             r_alu_valid;
  logic             r_tag;
  logic [1:0]       r_alu_op;
  logic [5:0]       r_alu_func;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_rsp0_valid;
  logic [WIDTH-1:0] r_rsp0_result;
  logic             r_rsp0_zero;
  logic             r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp1_result;
  logic             r_rsp1_zero;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             r_rr_last;
`endif

  logic w_elig0;
  logic w_elig1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_accept;

  // A requester with an op in flight or an unconsumed result must wait, so a
  // buffer can never be captured into and consumed on the same edge.
  assign w_elig0 = rst_n & ~flush & req0_valid & ~r_rsp0_valid & ~(r_alu_valid & ~r_tag);
  assign w_elig1 = rst_n & ~flush & req1_valid & ~r_rsp1_valid & ~(r_alu_valid &  r_tag);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_gnt0 = w_elig0;
  assign w_gnt1 = w_elig1 & ~w_elig0;
`else
  assign w_gnt0 = w_elig0 & (~w_elig1 |  r_rr_last);
  assign w_gnt1 = w_elig1 & (~w_elig0 | ~r_rr_last);
`endif

  assign w_accept   = w_gnt0 | w_gnt1;
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_valid   <= 1'b0;
      r_tag         <= 1'b0;
      r_alu_op      <= '0;
      r_alu_func    <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_zero   <= 1'b0;
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_zero   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_rr_last     <= 1'b1;
`endif
    end else if (flush) begin
      r_alu_valid  <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      if (r_rsp0_valid && rsp0_ready) r_rsp0_valid <= 1'b0;
      if (r_rsp1_valid && rsp1_ready) r_rsp1_valid <= 1'b0;
      if (r_alu_valid) begin
        if (r_tag) begin
          r_rsp1_result <= alu_result;
          r_rsp1_zero   <= alu_zero;
          r_rsp1_valid  <= 1'b1;
        end else begin
          r_rsp0_result <= alu_result;
          r_rsp0_zero   <= alu_zero;
          r_rsp0_valid  <= 1'b1;
        end
      end
      r_alu_valid <= w_accept;
      if (w_accept) begin
        r_tag      <= w_gnt1;
        r_alu_op   <= w_gnt1 ? req1_ALUOp : req0_ALUOp;
        r_alu_func <= w_gnt1 ? req1_Func  : req0_Func;
        r_alu_a    <= w_gnt1 ? req1_a     : req0_a;
        r_alu_b    <= w_gnt1 ? req1_b     : req0_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
        r_rr_last  <= w_gnt1;
`endif
      end
    end
  end

  assign alu_valid   = r_alu_valid;
  assign alu_ALUOp   = r_alu_op;
  assign alu_Func    = r_alu_func;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign rsp0_valid  = r_rsp0_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp0_zero   = r_rsp0_zero;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp1_result = r_rsp1_result;
  assign rsp1_zero   = r_rsp1_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
//------------------------------------------------------------------------------
// tb_alu_share_arbiter : directed self-checking bench for alu_share_arbiter,
//                        with a behavioural add/subtract ALU.
// Revision             : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_share_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_ALUOp;
  logic [5:0]       req0_Func;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_ALUOp;
  logic [5:0]       req1_Func;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             alu_valid;
  logic [1:0]       alu_ALUOp;
  logic [5:0]       alu_Func;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_zero;
  logic             rsp0_valid, rsp0_ready, rsp0_zero;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp1_valid, rsp1_ready, rsp1_zero;
  logic [WIDTH-1:0] rsp1_result;

  logic sub_mode;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  assign alu_result = sub_mode ? (alu_a - alu_b) : (alu_a + alu_b);
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ALUOp(req0_ALUOp),
    .req0_Func(req0_Func), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ALUOp(req1_ALUOp),
    .req1_Func(req1_Func), .req1_a(req1_a), .req1_b(req1_b),
    .alu_valid(alu_valid), .alu_ALUOp(alu_ALUOp), .alu_Func(alu_Func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; sub_mode = 1'b0;
    req0_valid = 1'b0; req0_ALUOp = '0; req0_Func = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ALUOp = '0; req1_Func = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #2;
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid got=%0d exp=0", alu_valid); end
    checks++; if (alu_a !== '0) begin errors++; $display("FAIL reset_alu_a got=%0h exp=0", alu_a); end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got=%0d exp=0", rsp0_valid); end
    checks++; if (rsp1_result !== '0) begin errors++; $display("FAIL reset_rsp1_result got=%0h exp=0", rsp1_result); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_alu_valid got=%0d exp=0", alu_valid); end
  endtask

  task automatic test_single_op();
    req0_valid = 1'b1; req0_ALUOp = 2'b10; req0_Func = 6'h20; req0_a = 5; req0_b = 7;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready got=%0d exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_req1_ready got=%0d exp=0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    #1;
    checks++; if (alu_valid !== 1'b1) begin errors++; $display("FAIL single_alu_valid got=%0d exp=1", alu_valid); end
    checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL single_alu_a got=%0d exp=5", alu_a); end
    checks++; if (alu_b !== 32'd7) begin errors++; $display("FAIL single_alu_b got=%0d exp=7", alu_b); end
    checks++; if (alu_ALUOp !== 2'b10) begin errors++; $display("FAIL single_alu_op got=%0d exp=2", alu_ALUOp); end
    checks++; if (alu_Func !== 6'h20) begin errors++; $display("FAIL single_alu_func got=%0h exp=20", alu_Func); end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp0_early got=%0d exp=0", rsp0_valid); end
    tick();
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL single_rsp0_valid got=%0d exp=1", rsp0_valid); end
    checks++; if (rsp0_result !== 32'd12) begin errors++; $display("FAIL single_rsp0_result got=%0d exp=12", rsp0_result); end
    checks++; if (rsp0_zero !== 1'b0) begin errors++; $display("FAIL single_rsp0_zero got=%0d exp=0", rsp0_zero); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL single_alu_idle got=%0d exp=0", alu_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_valid got=%0d exp=0", rsp1_valid); end
    rsp0_ready = 1'b1;
    tick();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp0_consumed got=%0d exp=0", rsp0_valid); end
  endtask

  // Last winner was requester 0, so a tie now separates round-robin from fixed priority.
  task automatic test_tie_after_req0();
    logic [1:0] exp_rdy;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_rdy = 2'b01;
`else
    exp_rdy = 2'b10;
`endif
    req0_valid = 1'b1; req0_a = 1; req0_b = 1;
    req1_valid = 1'b1; req1_a = 2; req1_b = 2;
    #1;
    checks++; if ({req1_ready, req0_ready} !== exp_rdy) begin errors++; $display("FAIL tie_grant got=%b exp=%b", {req1_ready, req0_ready}, exp_rdy); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [6];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b00;
    exp_g[3] = 2'b01; exp_g[4] = 2'b10; exp_g[5] = 2'b00;
    apply_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 1;  req0_b = 2;
    req1_valid = 1'b1; req1_a = 10; req1_b = 20;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if ({req1_ready, req0_ready} !== exp_g[i]) begin errors++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", i, {req1_ready, req0_ready}, exp_g[i]); end
      if (i == 2) begin
        checks++; if (rsp0_result !== 32'd3) begin errors++; $display("FAIL rr_rsp0_result got=%0d exp=3", rsp0_result); end
      end
      if (i == 3) begin
        checks++; if (rsp1_result !== 32'd30) begin errors++; $display("FAIL rr_rsp1_result got=%0d exp=30", rsp1_result); end
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4; req0_b = 4;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got=%0d exp=1", req0_ready); end
    tick();
    req0_a = 100; req0_b = 1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_inflight_ready got=%0d exp=0", req0_ready); end
    tick();
    req1_valid = 1'b1; req1_a = 2; req1_b = 3;
    #1;
    checks++; if (rsp0_result !== 32'd8) begin errors++; $display("FAIL bp_rsp0_result got=%0d exp=8", rsp0_result); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked_ready got=%0d exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_served got=%0d exp=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp1_valid got=%0d exp=1", rsp1_valid); end
    checks++; if (rsp1_result !== 32'd5) begin errors++; $display("FAIL bp_rsp1_result got=%0d exp=5", rsp1_result); end
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp0_held_valid got=%0d exp=1", rsp0_valid); end
    checks++; if (rsp0_result !== 32'd8) begin errors++; $display("FAIL bp_rsp0_held got=%0d exp=8", rsp0_result); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_still_blocked got=%0d exp=0", req0_ready); end
    rsp0_ready = 1'b1;
    tick();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp0_consumed got=%0d exp=0", rsp0_valid); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_restored got=%0d exp=1", req0_ready); end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++; if (rsp0_result !== 32'd101) begin errors++; $display("FAIL bp_second_result got=%0d exp=101", rsp0_result); end
    tick();
  endtask

  task automatic test_zero_flag();
    sub_mode = 1'b1; rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 9; req1_b = 9;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL zero_req1_ready got=%0d exp=1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL zero_rsp1_valid got=%0d exp=1", rsp1_valid); end
    checks++; if (rsp1_result !== 32'd0) begin errors++; $display("FAIL zero_rsp1_result got=%0d exp=0", rsp1_result); end
    checks++; if (rsp1_zero !== 1'b1) begin errors++; $display("FAIL zero_rsp1_zero got=%0d exp=1", rsp1_zero); end
    rsp1_ready = 1'b1; sub_mode = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    req0_valid = 1'b1; req0_a = 3; req0_b = 3;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL flush_pre_ready got=%0d exp=1", req0_ready); end
    tick();
    flush = 1'b1; req0_valid = 1'b0; req1_valid = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL flush_req1_ready got=%0d exp=0", req1_ready); end
    tick();
    flush = 1'b0; req1_valid = 1'b0; req0_valid = 1'b1;
    #1;
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL flush_alu_valid got=%0d exp=0", alu_valid); end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp0_valid got=%0d exp=0", rsp0_valid); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_restored got=%0d exp=1", req0_ready); end
    req0_valid = 1'b0;
    tick();
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin errors++; $display("FAIL flush_no_rsp got=%b exp=00", {rsp1_valid, rsp0_valid}); end
  endtask

  task automatic test_async_reset();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 1; req0_b = 1;
    #1;
    tick();
    req0_valid = 1'b0;
    tick();
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_rsp0 got=%0d exp=1", rsp0_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL areset_rsp0_valid got=%0d exp=0", rsp0_valid); end
    checks++; if (rsp0_result !== '0) begin errors++; $display("FAIL areset_rsp0_result got=%0h exp=0", rsp0_result); end
    checks++; if (alu_a !== '0) begin errors++; $display("FAIL areset_alu_a got=%0h exp=0", alu_a); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL areset_alu_valid got=%0d exp=0", alu_valid); end
    tick();
    rst_n = 1'b1; rsp0_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL areset_first_tie got=%b exp=01", {req1_ready, req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_op();
    test_tie_after_req0();
    test_round_robin();
    test_backpressure();
    test_zero_flag();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
